// File: rtl/lcd_frame_streamer.sv
// lcd_frame_streamer: scans (x, y) for the pixel renderer, samples its colour, and
// streams a memory-write command plus low/high colour bytes to the LCD bus driver.
// Latency: first byte valid the cycle after start. Backpressure: outputs hold while out_valid && !out_ready.
// Optional feature: define LCD_FRAME_AUTO_REPEAT_EN to stream frames back to back after one start.
module lcd_frame_streamer #(
   parameter int         H_PIXELS     = 320,
   parameter int         V_PIXELS     = 240,
   parameter logic [7:0] CMD_MEMWRITE = 8'h2C
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [143:0] cube_state_in,
   output logic [143:0] cube_state_frame,
   output logic [8:0]   x,
   output logic [7:0]   y,
   input  logic [15:0]  pixel_in,
   output logic [7:0]   out_data,
   output logic         out_dc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         frame_done
);

   localparam logic [8:0] X_LAST = 9'(H_PIXELS - 1);
   localparam logic [7:0] Y_LAST = 8'(V_PIXELS - 1);

   // S_FETCH is the one-cycle bubble after a coordinate advance: x/y are
   // registered by then, so pixel_in reflects the new coordinate.
   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_PIX_LO,
      S_PIX_HI,
      S_FETCH,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [8:0]     x_q, x_d;
   logic [7:0]     y_q, y_d;
   logic [143:0]   snap_q, snap_d;
   logic [15:0]    pix_q, pix_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           xfer;
   logic           last_pixel;

   assign xfer       = out_valid && out_ready;
   assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

   // State, coordinate, snapshot and pixel-latch registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         snap_q  <= '0;
         pix_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         snap_q  <= snap_d;
         pix_q   <= pix_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: scan order, pixel sampling and frame bookkeeping.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      snap_d  = snap_q;
      pix_d   = pix_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_d  = cube_state_in;
               x_d     = '0;
               y_d     = '0;
               busy_d  = 1'b1;
               state_d = S_CMD;
            end
         end

         S_CMD: begin
            // x/y have been 0 since start acceptance, so pixel_in is pixel (0,0).
            if (xfer) begin
               pix_d   = pixel_in;
               state_d = S_PIX_LO;
            end
         end

         S_PIX_LO: begin
            if (xfer) begin
               state_d = S_PIX_HI;
            end
         end

         S_PIX_HI: begin
            if (xfer) begin
               if (last_pixel) begin
                  // frame_done pulses while in S_DONE; start is ignored there.
                  done_d  = 1'b1;
`ifdef LCD_FRAME_AUTO_REPEAT_EN
                  busy_d  = 1'b1;
`else
                  busy_d  = 1'b0;
`endif
                  state_d = S_DONE;
               end else begin
                  if (x_q == X_LAST) begin
                     x_d = '0;
                     y_d = y_q + 8'd1;
                  end else begin
                     x_d = x_q + 9'd1;
                  end
                  state_d = S_FETCH;
               end
            end
         end

         S_FETCH: begin
            pix_d   = pixel_in;
            state_d = S_PIX_LO;
         end

         S_DONE: begin
`ifdef LCD_FRAME_AUTO_REPEAT_EN
            snap_d  = cube_state_in;
            x_d     = '0;
            y_d     = '0;
            state_d = S_CMD;
`else
            state_d = S_IDLE;
`endif
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from registered state only, so bytes stay stable under backpressure.
   always_comb begin
      out_valid = 1'b0;
      out_dc    = 1'b0;
      out_data  = 8'h00;
      case (state_q)
         S_CMD: begin
            out_valid = 1'b1;
            out_dc    = 1'b0;
            out_data  = CMD_MEMWRITE;
         end
         S_PIX_LO: begin
            out_valid = 1'b1;
            out_dc    = 1'b1;
            out_data  = pix_q[7:0];
         end
         S_PIX_HI: begin
            out_valid = 1'b1;
            out_dc    = 1'b1;
            out_data  = pix_q[15:8];
         end
         default: begin
            out_valid = 1'b0;
            out_dc    = 1'b0;
            out_data  = 8'h00;
         end
      endcase
   end

   assign cube_state_frame = snap_q;
   assign x                = x_q;
   assign y                = y_q;
   assign busy             = busy_q;
   assign frame_done       = done_q;

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Bench for lcd_frame_streamer on a reduced 6x3 raster with a {x[7:0], y} renderer model.
// Stimulus queues expected bytes; a negedge monitor pops and compares each transfer.
// Covers reset, ordering, line wrap, snapshot, backpressure, stuck ready and mid-frame reset.
module tb_lcd_frame_streamer;

   localparam int H           = 6;
   localparam int V           = 3;
   localparam int FRAME_BYTES = 1 + 2 * H * V;   // 37

   typedef struct packed {
      logic       dc;
      logic [7:0] dat;
      logic [8:0] ex;
      logic [7:0] ey;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic [143:0] cube_state_in;
   logic [143:0] cube_state_frame;
   logic [8:0]   x;
   logic [7:0]   y;
   logic [15:0]  pixel_in;
   logic [7:0]   out_data;
   logic         out_dc;
   logic         out_valid;
   logic         out_ready;
   logic         busy;
   logic         frame_done;

   exp_t         exp_q[$];
   exp_t         mon_e;
   logic [143:0] exp_snap = '0;
   int           checks    = 0;
   int           failures  = 0;
   int           byte_cnt  = 0;
   int           done_cnt  = 0;
   logic         rnd_en    = 1'b0;
   logic         rdy_fix   = 1'b1;
   logic         hold_vld  = 1'b0;
   logic [7:0]   hold_dat  = '0;
   logic         hold_dc   = 1'b0;

   localparam logic [143:0] ALL_111 = {48{3'b111}};
   localparam logic [143:0] ALL_100 = {48{3'b100}};

   always #5 clock = ~clock;

   // Renderer model: colour = {x[7:0], y}
   assign pixel_in = {x[7:0], y};

   lcd_frame_streamer #(.H_PIXELS(H), .V_PIXELS(V), .CMD_MEMWRITE(8'h2C)) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .cube_state_in    (cube_state_in),
      .cube_state_frame (cube_state_frame),
      .x                (x),
      .y                (y),
      .pixel_in         (pixel_in),
      .out_data         (out_data),
      .out_dc           (out_dc),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .busy             (busy),
      .frame_done       (frame_done)
   );

   task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Expected byte stream for one frame: command, then low/high colour per pixel.
   task automatic push_frame();
      exp_t e;
      logic [8:0] xi;
      logic [7:0] yi;
      e = '{dc: 1'b0, dat: 8'h2C, ex: 9'd0, ey: 8'd0};
      exp_q.push_back(e);
      for (int j = 0; j < V; j++) begin
         for (int i = 0; i < H; i++) begin
            xi = 9'(i);
            yi = 8'(j);
            e = '{dc: 1'b1, dat: yi, ex: xi, ey: yi};
            exp_q.push_back(e);
            e = '{dc: 1'b1, dat: xi[7:0], ex: xi, ey: yi};
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic start_frame();
      push_frame();
      exp_snap = cube_state_in;
      @(posedge clock); #1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("snap_after_start", cube_state_frame, exp_snap);
   endtask

   task automatic wait_bytes(input int n);
      int t = 0;
      while (byte_cnt < n && t < 5000) begin
         @(negedge clock);
         t++;
      end
      chk("wait_bytes_timeout", (byte_cnt >= n), 1);
   endtask

   task automatic wait_done();
      int t = 0;
      @(negedge clock);
      while (!frame_done && t < 5000) begin
         @(negedge clock);
         t++;
      end
      chk("frame_done_timeout", frame_done, 1);
   endtask

   // Ready driver: fixed level or ~30% pseudo-random duty.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock); #1;
         out_ready = rnd_en ? ($urandom_range(0, 9) < 3) : rdy_fix;
      end
   end

   // Monitor: compares every transfer with the scoreboard head and checks hold rules.
   always @(negedge clock) begin
      if (reset) begin
         hold_vld = 1'b0;
      end else begin
         if (hold_vld) begin
            chk("stall_valid_hold", out_valid, 1);
            chk("stall_data_hold", out_data, hold_dat);
            chk("stall_dc_hold", out_dc, hold_dc);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", out_data, 0);
               chk("unexpected_byte_vld", 0, 1);
            end else begin
               mon_e = exp_q.pop_front();
               chk("byte_dc", out_dc, mon_e.dc);
               chk("byte_data", out_data, mon_e.dat);
               chk("byte_x", x, mon_e.ex);
               chk("byte_y", y, mon_e.ey);
               chk("byte_snapshot", cube_state_frame, exp_snap);
            end
            byte_cnt++;
         end
         hold_vld = out_valid && !out_ready;
         hold_dat = out_data;
         hold_dc  = out_dc;
         if (frame_done) begin
            done_cnt++;
            chk("busy_low_with_done", busy, 0);
            chk("queue_empty_at_done", exp_q.size(), 0);
            chk("x_at_done", x, H - 1);
            chk("y_at_done", y, V - 1);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int d0;
      logic [8:0] hx;
      logic [7:0] hy;
      int hb;

      reset         = 1'b1;
      start         = 1'b0;
      cube_state_in = {9{16'hA5C3}};
      repeat (3) @(posedge clock);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_snap", cube_state_frame, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_data", out_data, 0);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("idle_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_snap", cube_state_frame, 0);

      // Frame 1: unstalled, start while busy, start on the done pulse.
      base = byte_cnt;
      d0   = done_cnt;
      start_frame();
      repeat (10) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      wait_done();
      chk("frame1_bytes", byte_cnt - base, FRAME_BYTES);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      chk("post_done_valid", out_valid, 0);
      chk("post_done_busy", busy, 0);
      chk("frame1_done_count", done_cnt - d0, 1);

      // Frame 2: cube_state_in changes mid-frame; snapshot must not move.
      cube_state_in = ALL_111;
      base = byte_cnt;
      start_frame();
      wait_bytes(base + 15);
      cube_state_in = ALL_100;
      wait_done();
      chk("frame2_snap_kept", cube_state_frame, ALL_111);
      chk("frame2_bytes", byte_cnt - base, FRAME_BYTES);
      repeat (2) @(posedge clock);

      // Frame 3: random backpressure plus a long stuck-low ready stretch.
      rnd_en = 1'b1;
      base = byte_cnt;
      start_frame();
      chk("frame3_snap_new", cube_state_frame, ALL_100);
      wait_bytes(base + 12);
      rdy_fix = 1'b0;
      rnd_en  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      hx = x;
      hy = y;
      hb = byte_cnt;
      repeat (20) @(posedge clock);
      #1;
      chk("stuck_x", x, hx);
      chk("stuck_y", y, hy);
      chk("stuck_bytes", byte_cnt, hb);
      chk("stuck_valid", out_valid, 1);
      rnd_en = 1'b1;
      wait_done();
      chk("frame3_bytes", byte_cnt - base, FRAME_BYTES);
      rnd_en  = 1'b0;
      rdy_fix = 1'b1;
      repeat (2) @(posedge clock);

      // Frame 4: reset mid-frame, then frame 5 restarts cleanly.
      cube_state_in = {9{16'h0F1E}};
      base = byte_cnt;
      start_frame();
      wait_bytes(base + 20);
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_x", x, 0);
      chk("abort_y", y, 0);
      chk("abort_snap", cube_state_frame, 0);
      chk("abort_data", out_data, 0);
      chk("abort_dc", out_dc, 0);
      exp_q.delete();
      d0 = done_cnt;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("abort_no_done", done_cnt, d0);
      base = byte_cnt;
      start_frame();
      wait_done();
      chk("frame5_bytes", byte_cnt - base, FRAME_BYTES);
      repeat (3) @(posedge clock);
      #1;
      chk("frame5_done_count", done_cnt - d0, 1);
      chk("final_valid", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_frame_streamer.md
Name: lcd_frame_streamer

Overview:
- Scan and stream stage sitting directly upstream of the cube-state pixel renderer.
- Generates the pixel coordinate scan (x, y) that the renderer consumes, and samples the renderer's 16-bit colour for each coordinate.
- Sends each colour as a byte stream, preceded by a memory-write command, to the LCD bus driver over a valid/ready handshake.
- Snapshots the 144-bit cube state at frame start, so the renderer sees a stable state for the whole frame (no tearing).

Parameters:
- H_PIXELS, 320, pixels per line; x counts 0..H_PIXELS-1.
- V_PIXELS, 240, lines per frame; y counts 0..V_PIXELS-1.
- CMD_MEMWRITE, 8'h2C, command byte emitted with dc=0 before pixel data.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin one frame; ignored unless idle
- cube_state_in  in  144  live cube state from the input logic
- cube_state_frame  out  144  frame-stable snapshot, driven to the renderer
- x  out  9  current pixel column, driven to the renderer
- y  out  8  current pixel row, driven to the renderer
- pixel_in  in  16  renderer colour for (x, y); combinational, same cycle
- out_data  out  8  byte to the LCD bus driver
- out_dc  out  1  0 = command byte, 1 = data byte
- out_valid  out  1  out_data/out_dc valid
- out_ready  in  1  LCD bus driver accepts the byte when valid&&ready
- busy  out  1  high from start acceptance until frame_done
- frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted

Behaviour:
- Clock and reset: reset is asynchronous and active-high; one clock domain (clock).
- Reset values: state=IDLE, x=0, y=0, cube_state_frame=0, out_data=0, out_dc=0, out_valid=0, busy=0, frame_done=0, pixel latch=0.
- Transfer rule: a byte transfers on any cycle where out_valid && out_ready.
  - While out_valid=1, out_data and out_dc hold stable until the transfer.
  - out_valid never deasserts without a transfer, except on reset.
- States: IDLE, CMD, PIX_LO, PIX_HI, DONE.
- IDLE:
  - On start=1: latch cube_state_in into cube_state_frame; set x=0, y=0, busy=1.
  - Next cycle: CMD with out_valid=1, out_dc=0, out_data=CMD_MEMWRITE.
- CMD, on transfer:
  - Latch pixel_in (the renderer output for x=0, y=0 on the latched snapshot).
  - Go to PIX_LO: out_dc=1, out_data=pixel[7:0].
- PIX_LO, on transfer: go to PIX_HI with out_data=pixel[15:8].
  - Byte order is low byte first, matching the renderer's byte-swapped colour constants.
- PIX_HI, on transfer:
  - If x == H_PIXELS-1 and y == V_PIXELS-1: go to DONE with out_valid=0.
  - Otherwise advance the coordinate:
    - x increments.
    - At x == H_PIXELS-1, x wraps to 0 and y increments.
  - Then go to PIX_LO, latching pixel_in for the new coordinate on the following cycle. A one-cycle bubble with out_valid=0 is permitted so that pixel_in is sampled only after x/y have settled; that cycle's pixel_in is the registered-coordinate result.
- DONE: pulse frame_done=1 for exactly one cycle, clear busy, return to IDLE.
- Throughput: ≤3 cycles per pixel with out_ready held high. Total frame bytes = 1 + 2·H_PIXELS·V_PIXELS (153601 at the defaults).
- x and y change only in PIX_HI→next transitions; they hold at their last values in IDLE.
- cube_state_frame changes only on start acceptance. Changes on cube_state_in mid-frame have no effect until the next frame.
- start while busy: ignored, no queuing. start in the same cycle as the frame_done pulse: ignored.
- out_ready held low indefinitely: all outputs hold, no counter advance.
- Reset mid-frame: all outputs return to their reset values immediately. The partially sent frame is abandoned; no frame_done is issued.

Optional Feature:
- Macro: LCD_FRAME_AUTO_REPEAT_EN.
- Defined: on leaving DONE, the block immediately re-enters the CMD state with a fresh cube_state snapshot. It streams continuously after a single start and ignores further start pulses; frame_done still pulses once per frame; busy stays 1.
- Undefined: one frame per start pulse, as described above.

Test Plan:
- Reset then idle: assert reset with no start → out_valid=0, busy=0, x=0, y=0, cube_state_frame=0.
- Single frame, out_ready=1, renderer model returns {x[7:0], y}:
  - First byte is 8'h2C with dc=0.
  - Next bytes are 8'h00, 8'h00 (pixel 0,0), then 8'h00, 8'h01 (pixel 1,0).
  - Exactly 153601 bytes in total; frame_done pulses once; busy falls the same cycle as the pulse.
- Backpressure: toggle out_ready pseudo-randomly at 30% duty → byte sequence identical to the unstalled run, and out_data stays stable whenever valid && !ready.
- Snapshot: change cube_state_in from all 3'b111 to all 3'b100 at pixel 5000 → cube_state_frame stays all-111 for the whole frame, then is all-100 after the next start.
- Line wrap: at x=319, y=0, on the PIX_HI transfer → x=0, y=1; at x=319, y=239 → DONE, no y overflow.
- Reset mid-frame at byte 1000, then start → stream restarts with 8'h2C and pixel (0,0); no frame_done is issued for the aborted frame.
